// File: rtl/pd_link_manager.sv
// Packet-descriptor pointer manager.
// One next-pointer store holds a free list and NUM_Q per-queue linked lists.
// Admission pops the free head and appends it to a queue in one handshake,
// cell read pops a queue head, and the release port appends to the free tail.
module pd_link_manager #(
  parameter int NUM_Q = 8,
  parameter int DEPTH = 1024,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int QID_W = $clog2(NUM_Q)
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         init_done,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [QID_W-1:0]             enq_qid,
  input  logic                         enq_eop,
  output logic [PTR_W-1:0]             enq_ptr,
  input  logic                         deq_valid,
  input  logic [QID_W-1:0]             deq_qid,
  output logic                         deq_ready,
  output logic                         deq_ptr_vld,
  output logic [PTR_W-1:0]             deq_ptr,
  output logic                         deq_ptr_eop,
  input  logic                         rel_valid,
  input  logic [PTR_W-1:0]             rel_ptr,
  output logic [PTR_W:0]               free_cnt,
  output logic [NUM_Q-1:0]             q_frame_rdy,
  output logic [NUM_Q*(PTR_W+1)-1:0]   q_cnt
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state;
  logic [PTR_W-1:0]  init_idx;
  logic [PTR_W-1:0]  next_mem [DEPTH];
  logic [DEPTH-1:0]  eop_mem;

  logic [PTR_W-1:0]  free_head;
  logic [PTR_W-1:0]  free_tail;
  logic [PTR_W:0]    free_cnt_r;

  logic [PTR_W-1:0]  q_head    [NUM_Q];
  logic [PTR_W-1:0]  q_tail    [NUM_Q];
  logic [PTR_W:0]    q_cnt_r   [NUM_Q];
  logic [PTR_W:0]    frame_cnt [NUM_Q];

  logic              enq_fire;
  logic              deq_fire;
  logic              rel_fire;
  logic [PTR_W-1:0]  deq_head;
  logic [PTR_W-1:0]  deq_next;
  logic              deq_eop_cur;
  logic [PTR_W-1:0]  free_next;
  logic [PTR_W-1:0]  enq_tail;
  logic              enq_q_nonempty;
  logic [PTR_W:0]    free_after_pop;
  logic [NUM_Q-1:0]  enq_hit;
  logic [NUM_Q-1:0]  deq_hit;

  // Handshake status is derived only from registered state
  assign enq_ready      = init_done && (free_cnt_r != '0);
  assign deq_ready      = init_done && (q_cnt_r[deq_qid] != '0);
  assign enq_ptr        = free_head;
  assign free_cnt       = free_cnt_r;

  assign enq_fire       = enq_valid && enq_ready;
  assign deq_fire       = deq_valid && deq_ready;
  assign rel_fire       = rel_valid && init_done;

  assign deq_head       = q_head[deq_qid];
  assign deq_next       = next_mem[deq_head];
  assign deq_eop_cur    = eop_mem[deq_head];
  assign free_next      = next_mem[free_head];
  assign enq_tail       = q_tail[enq_qid];
  assign enq_q_nonempty = (q_cnt_r[enq_qid] != '0);
  assign free_after_pop = free_cnt_r - {{PTR_W{1'b0}}, enq_fire};

  // Decode which queue each handshake targets this cycle
  always_comb begin
    enq_hit = '0;
    deq_hit = '0;
    for (int q = 0; q < NUM_Q; q++) begin
      enq_hit[q] = enq_fire && (enq_qid == QID_W'(q));
      deq_hit[q] = deq_fire && (deq_qid == QID_W'(q));
    end
  end

  // Flatten per-queue counters onto the output buses
  always_comb begin
    q_cnt       = '0;
    q_frame_rdy = '0;
    for (int q = 0; q < NUM_Q; q++) begin
      q_cnt[q*(PTR_W+1) +: PTR_W+1] = q_cnt_r[q];
      q_frame_rdy[q]                = (frame_cnt[q] != '0);
    end
  end

  // Link store: chain build during INIT, then queue appends and free-tail appends
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        next_mem[init_idx] <= init_idx + PTR_ONE;
      end else begin
        if (enq_fire) begin
          eop_mem[free_head] <= enq_eop;
          if (enq_q_nonempty)
            next_mem[enq_tail] <= free_head;
        end
        if (rel_fire && (free_after_pop != '0))
          next_mem[free_tail] <= rel_ptr;
      end
    end
  end

  // Control FSM plus free-list, per-queue and dequeue-result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_INIT;
      init_idx    <= '0;
      init_done   <= 1'b0;
      free_head   <= '0;
      free_tail   <= '0;
      free_cnt_r  <= '0;
      deq_ptr_vld <= 1'b0;
      deq_ptr     <= '0;
      deq_ptr_eop <= 1'b0;
      for (int q = 0; q < NUM_Q; q++) begin
        q_head[q]    <= '0;
        q_tail[q]    <= '0;
        q_cnt_r[q]   <= '0;
        frame_cnt[q] <= '0;
      end
    end else begin
      case (state)
        ST_INIT: begin
          deq_ptr_vld <= 1'b0;
          init_idx    <= init_idx + PTR_ONE;
          if (init_idx == PTR_LAST) begin
            free_head  <= '0;
            free_tail  <= PTR_LAST;
            free_cnt_r <= CNT_FULL;
            init_done  <= 1'b1;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (rel_fire && (free_after_pop == '0)) begin
            free_head <= rel_ptr;
            free_tail <= rel_ptr;
          end else begin
            if (enq_fire) free_head <= free_next;
            if (rel_fire) free_tail <= rel_ptr;
          end
          case ({enq_fire, rel_fire})
            2'b10:   free_cnt_r <= free_cnt_r - CNT_ONE;
            2'b01:   free_cnt_r <= free_cnt_r + CNT_ONE;
            default: free_cnt_r <= free_cnt_r;
          endcase

          deq_ptr_vld <= deq_fire;
          if (deq_fire) begin
            deq_ptr     <= deq_head;
            deq_ptr_eop <= deq_eop_cur;
          end

          for (int q = 0; q < NUM_Q; q++) begin
            if (enq_hit[q] && deq_hit[q]) begin
              if (q_cnt_r[q] == CNT_ONE) q_head[q] <= free_head;
              else                       q_head[q] <= deq_next;
              q_tail[q] <= free_head;
            end else if (enq_hit[q]) begin
              if (q_cnt_r[q] == '0) q_head[q] <= free_head;
              q_tail[q]  <= free_head;
              q_cnt_r[q] <= q_cnt_r[q] + CNT_ONE;
            end else if (deq_hit[q]) begin
              if (q_cnt_r[q] != CNT_ONE) q_head[q] <= deq_next;
              q_cnt_r[q] <= q_cnt_r[q] - CNT_ONE;
            end
            if (enq_hit[q] && enq_eop && !(deq_hit[q] && deq_eop_cur))
              frame_cnt[q] <= frame_cnt[q] + CNT_ONE;
            else if (deq_hit[q] && deq_eop_cur && !(enq_hit[q] && enq_eop))
              frame_cnt[q] <= frame_cnt[q] - CNT_ONE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pd_link_manager.sv
// Self-checking bench for pd_link_manager (NUM_Q=4, DEPTH=16).
// A queue-based reference model tracks the free list, each queue's contents
// and the pointers handed out by dequeue; the DUT is compared against it.
module tb_pd_link_manager;

  localparam int NQ    = 4;
  localparam int DEPTH = 16;
  localparam int PW    = 4;
  localparam int QW    = 2;
  localparam int CW    = PW + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            init_done;
  logic            enq_valid;
  logic            enq_ready;
  logic [QW-1:0]   enq_qid;
  logic            enq_eop;
  logic [PW-1:0]   enq_ptr;
  logic            deq_valid;
  logic [QW-1:0]   deq_qid;
  logic            deq_ready;
  logic            deq_ptr_vld;
  logic [PW-1:0]   deq_ptr;
  logic            deq_ptr_eop;
  logic            rel_valid;
  logic [PW-1:0]   rel_ptr;
  logic [PW:0]     free_cnt;
  logic [NQ-1:0]   q_frame_rdy;
  logic [NQ*CW-1:0] q_cnt;

  pd_link_manager #(.NUM_Q(NQ), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_qid(enq_qid),
    .enq_eop(enq_eop), .enq_ptr(enq_ptr),
    .deq_valid(deq_valid), .deq_qid(deq_qid), .deq_ready(deq_ready),
    .deq_ptr_vld(deq_ptr_vld), .deq_ptr(deq_ptr), .deq_ptr_eop(deq_ptr_eop),
    .rel_valid(rel_valid), .rel_ptr(rel_ptr),
    .free_cnt(free_cnt), .q_frame_rdy(q_frame_rdy), .q_cnt(q_cnt)
  );

  // Free-running clock
  always #5 clk = ~clk;

  typedef struct { int ptr; bit eop; } ent_t;

  ent_t qm [NQ][$];
  int   free_q[$];
  int   held[$];
  bit   m_init;
  int   m_icnt;
  bit   m_vld;
  int   m_dptr;
  bit   m_deop;

  int checks = 0;
  int errors = 0;

  function automatic int frames(int q);
    int n = 0;
    for (int i = 0; i < qm[q].size(); i++)
      if (qm[q][i].eop) n++;
    return n;
  endfunction

  task automatic idle();
    enq_valid = 1'b0; enq_qid = '0; enq_eop = 1'b0;
    deq_valid = 1'b0; deq_qid = '0;
    rel_valid = 1'b0; rel_ptr = '0;
  endtask

  // One clock edge: advance the model from the inputs presented, then settle
  task automatic step();
    bit en, dn, rn;
    ent_t e;
    int p;
    @(posedge clk);
    if (rst) begin
      for (int q = 0; q < NQ; q++) qm[q].delete();
      free_q.delete(); held.delete();
      m_init = 0; m_icnt = 0; m_vld = 0; m_dptr = 0; m_deop = 0;
    end else if (!m_init) begin
      m_vld = 0;
      m_icnt++;
      if (m_icnt == DEPTH) begin
        m_init = 1;
        for (int i = 0; i < DEPTH; i++) free_q.push_back(i);
      end
    end else begin
      en = enq_valid && (free_q.size() != 0);
      dn = deq_valid && (qm[deq_qid].size() != 0);
      rn = rel_valid;
      m_vld = dn;
      if (dn) begin
        e = qm[deq_qid].pop_front();
        m_dptr = e.ptr; m_deop = e.eop;
        held.push_back(e.ptr);
      end
      if (en) begin
        p = free_q.pop_front();
        e.ptr = p; e.eop = enq_eop;
        qm[enq_qid].push_back(e);
      end
      if (rn) begin
        free_q.push_back(int'(rel_ptr));
        for (int i = 0; i < held.size(); i++)
          if (held[i] == int'(rel_ptr)) begin held.delete(i); break; end
      end
    end
    #1;
  endtask

  // Empty every queue and return every held pointer
  task automatic drain_all();
    for (int n = 0; n < 200; n++) begin
      idle();
      for (int q = 0; q < NQ; q++)
        if (!deq_valid && qm[q].size() != 0) begin deq_valid = 1'b1; deq_qid = QW'(q); end
      if (held.size() != 0) begin rel_valid = 1'b1; rel_ptr = PW'(held[0]); end
      if (!deq_valid && !rel_valid) break;
      step();
    end
    idle();
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; idle(); step();
    checks++; if (init_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_init_done: got %0b expected 0", init_done); end
    checks++; if (deq_ptr_vld !== 1'b0 || deq_ptr !== '0 || deq_ptr_eop !== 1'b0) begin errors++; $display("[TB] FAIL rst_deq: got vld=%0b ptr=%0d eop=%0b expected 0/0/0", deq_ptr_vld, deq_ptr, deq_ptr_eop); end
    checks++; if (free_cnt !== '0 || q_cnt !== '0 || q_frame_rdy !== '0) begin errors++; $display("[TB] FAIL rst_counts: got free=%0d qcnt=%h frdy=%b expected 0", free_cnt, q_cnt, q_frame_rdy); end
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_enq_ready: got %0b expected 0", enq_ready); end
    rst = 1'b0;
    n = 0;
    while (init_done !== 1'b1 && n < 100) begin step(); n++; end
    checks++; if (n != DEPTH) begin errors++; $display("[TB] FAIL init_latency: got %0d cycles expected %0d", n, DEPTH); end
    checks++; if (free_cnt !== CW'(DEPTH) || enq_ptr !== '0 || enq_ready !== 1'b1) begin errors++; $display("[TB] FAIL init_state: got free=%0d ptr=%0d rdy=%0b expected 16/0/1", free_cnt, enq_ptr, enq_ready); end
  endtask

  task automatic test_fifo();
    for (int k = 0; k < 3; k++) begin
      checks++; if (enq_ptr !== PW'(k)) begin errors++; $display("[TB] FAIL fifo_enq_ptr%0d: got %0d expected %0d", k, enq_ptr, k); end
      idle(); enq_valid = 1'b1; enq_qid = 2'd2; enq_eop = (k == 2);
      step();
    end
    idle();
    checks++; if (q_cnt[2*CW +: CW] !== CW'(3) || q_frame_rdy[2] !== 1'b1) begin errors++; $display("[TB] FAIL fifo_fill: got cnt=%0d frdy=%0b expected 3/1", q_cnt[2*CW +: CW], q_frame_rdy[2]); end
    for (int k = 0; k < 3; k++) begin
      deq_valid = 1'b1; deq_qid = 2'd2;
      step();
      checks++; if (deq_ptr_vld !== 1'b1 || deq_ptr !== PW'(k) || deq_ptr_eop !== (k == 2)) begin errors++; $display("[TB] FAIL fifo_deq%0d: got vld=%0b ptr=%0d eop=%0b expected 1/%0d/%0b", k, deq_ptr_vld, deq_ptr, deq_ptr_eop, k, k == 2); end
    end
    idle(); step();
    checks++; if (deq_ptr_vld !== 1'b0 || q_frame_rdy[2] !== 1'b0 || q_cnt[2*CW +: CW] !== '0) begin errors++; $display("[TB] FAIL fifo_empty: got vld=%0b frdy=%0b cnt=%0d expected 0/0/0", deq_ptr_vld, q_frame_rdy[2], q_cnt[2*CW +: CW]); end
    drain_all();
    checks++; if (free_cnt !== CW'(DEPTH)) begin errors++; $display("[TB] FAIL fifo_restore: got %0d expected 16", free_cnt); end
  endtask

  task automatic test_full();
    for (int k = 0; k < DEPTH; k++) begin
      idle(); enq_valid = 1'b1; enq_qid = 2'd0; enq_eop = 1'($urandom_range(0, 1));
      step();
    end
    checks++; if (enq_ready !== 1'b0 || free_cnt !== '0 || q_cnt[0 +: CW] !== CW'(DEPTH)) begin errors++; $display("[TB] FAIL full_state: got rdy=%0b free=%0d cnt=%0d expected 0/0/16", enq_ready, free_cnt, q_cnt[0 +: CW]); end
    step();
    checks++; if (free_cnt !== '0 || q_cnt[0 +: CW] !== CW'(DEPTH)) begin errors++; $display("[TB] FAIL full_ignore: got free=%0d cnt=%0d expected 0/16", free_cnt, q_cnt[0 +: CW]); end
    idle();
    for (int k = 0; k < DEPTH; k++) begin
      deq_valid = 1'b1; deq_qid = 2'd0;
      step();
      checks++; if (deq_ptr_vld !== 1'b1 || deq_ptr !== PW'(m_dptr) || deq_ptr_eop !== m_deop) begin errors++; $display("[TB] FAIL full_deq%0d: got ptr=%0d eop=%0b expected %0d/%0b", k, deq_ptr, deq_ptr_eop, m_dptr, m_deop); end
    end
    idle();
    rel_valid = 1'b1; rel_ptr = 4'd5;
    step(); idle();
    checks++; if (enq_ptr !== 4'd5 || enq_ready !== 1'b1 || free_cnt !== CW'(1)) begin errors++; $display("[TB] FAIL full_rel5: got ptr=%0d rdy=%0b free=%0d expected 5/1/1", enq_ptr, enq_ready, free_cnt); end
    drain_all();
    checks++; if (free_cnt !== CW'(DEPTH)) begin errors++; $display("[TB] FAIL full_restore: got %0d expected 16", free_cnt); end
  endtask

  task automatic test_same_queue();
    int a, b;
    a = free_q[0];
    idle(); enq_valid = 1'b1; enq_qid = 2'd1; step();
    b = free_q[0];
    enq_valid = 1'b1; enq_qid = 2'd1; deq_valid = 1'b1; deq_qid = 2'd1;
    step(); idle();
    checks++; if (q_cnt[1*CW +: CW] !== CW'(1)) begin errors++; $display("[TB] FAIL sameq_cnt: got %0d expected 1", q_cnt[1*CW +: CW]); end
    checks++; if (deq_ptr_vld !== 1'b1 || deq_ptr !== PW'(a)) begin errors++; $display("[TB] FAIL sameq_old: got vld=%0b ptr=%0d expected 1/%0d", deq_ptr_vld, deq_ptr, a); end
    deq_valid = 1'b1; deq_qid = 2'd1; step(); idle();
    checks++; if (deq_ptr_vld !== 1'b1 || deq_ptr !== PW'(b) || q_cnt[1*CW +: CW] !== '0) begin errors++; $display("[TB] FAIL sameq_new: got ptr=%0d cnt=%0d expected %0d/0", deq_ptr, q_cnt[1*CW +: CW], b); end
    drain_all();
  endtask

  task automatic test_last_free_rel();
    int x;
    for (int k = 0; k < DEPTH - 1; k++) begin
      idle(); enq_valid = 1'b1; enq_qid = 2'd3; enq_eop = 1'($urandom_range(0, 1)); step();
    end
    idle();
    checks++; if (free_cnt !== CW'(1)) begin errors++; $display("[TB] FAIL lastfree_cnt: got %0d expected 1", free_cnt); end
    deq_valid = 1'b1; deq_qid = 2'd3; step(); idle();
    x = m_dptr;
    enq_valid = 1'b1; enq_qid = 2'd3; rel_valid = 1'b1; rel_ptr = PW'(x);
    step(); idle();
    checks++; if (free_cnt !== CW'(1) || enq_ptr !== PW'(x) || enq_ready !== 1'b1) begin errors++; $display("[TB] FAIL lastfree_rel: got free=%0d ptr=%0d rdy=%0b expected 1/%0d/1", free_cnt, enq_ptr, enq_ready, x); end
    checks++; if (q_cnt[3*CW +: CW] !== CW'(DEPTH - 1)) begin errors++; $display("[TB] FAIL lastfree_qcnt: got %0d expected 15", q_cnt[3*CW +: CW]); end
    drain_all();
    checks++; if (free_cnt !== CW'(DEPTH) || q_cnt !== '0) begin errors++; $display("[TB] FAIL lastfree_restore: got free=%0d qcnt=%h expected 16/0", free_cnt, q_cnt); end
  endtask

  task automatic test_random(input int ncycles);
    for (int c = 0; c < ncycles; c++) begin
      idle();
      enq_valid = ($urandom_range(0, 9) < 6);
      enq_qid   = QW'($urandom_range(0, NQ - 1));
      enq_eop   = 1'($urandom_range(0, 1));
      deq_valid = ($urandom_range(0, 1) == 1);
      deq_qid   = QW'($urandom_range(0, NQ - 1));
      if (held.size() != 0 && $urandom_range(0, 1) == 1) begin
        rel_valid = 1'b1;
        rel_ptr   = PW'(held[$urandom_range(0, held.size() - 1)]);
      end
      step();
      checks++; if (free_cnt !== CW'(free_q.size()) || enq_ready !== (free_q.size() != 0)) begin errors++; $display("[TB] FAIL rand_free c%0d: got free=%0d rdy=%0b expected %0d/%0b", c, free_cnt, enq_ready, free_q.size(), free_q.size() != 0); end
      if (free_q.size() != 0) begin
        checks++; if (enq_ptr !== PW'(free_q[0])) begin errors++; $display("[TB] FAIL rand_enq_ptr c%0d: got %0d expected %0d", c, enq_ptr, free_q[0]); end
      end
      checks++; if (deq_ptr_vld !== m_vld) begin errors++; $display("[TB] FAIL rand_deq_vld c%0d: got %0b expected %0b", c, deq_ptr_vld, m_vld); end
      if (m_vld) begin
        checks++; if (deq_ptr !== PW'(m_dptr) || deq_ptr_eop !== m_deop) begin errors++; $display("[TB] FAIL rand_deq c%0d: got ptr=%0d eop=%0b expected %0d/%0b", c, deq_ptr, deq_ptr_eop, m_dptr, m_deop); end
      end
      for (int q = 0; q < NQ; q++) begin
        checks++; if (q_cnt[q*CW +: CW] !== CW'(qm[q].size()) || q_frame_rdy[q] !== (frames(q) != 0)) begin errors++; $display("[TB] FAIL rand_q%0d c%0d: got cnt=%0d frdy=%0b expected %0d/%0b", q, c, q_cnt[q*CW +: CW], q_frame_rdy[q], qm[q].size(), frames(q) != 0); end
      end
    end
    idle();
  endtask

  task automatic test_mid_reset();
    int n;
    test_random(60);
    rst = 1'b1; idle(); step();
    checks++; if (init_done !== 1'b0 || enq_ready !== 1'b0 || deq_ptr_vld !== 1'b0 || deq_ptr !== '0) begin errors++; $display("[TB] FAIL midrst_out: got done=%0b rdy=%0b vld=%0b ptr=%0d expected 0/0/0/0", init_done, enq_ready, deq_ptr_vld, deq_ptr); end
    checks++; if (free_cnt !== '0 || q_cnt !== '0 || q_frame_rdy !== '0) begin errors++; $display("[TB] FAIL midrst_counts: got free=%0d qcnt=%h frdy=%b expected 0", free_cnt, q_cnt, q_frame_rdy); end
    rst = 1'b0;
    n = 0;
    while (init_done !== 1'b1 && n < 100) begin step(); n++; end
    checks++; if (n != DEPTH || free_cnt !== CW'(DEPTH) || enq_ptr !== '0) begin errors++; $display("[TB] FAIL midrst_rebuild: got cycles=%0d free=%0d ptr=%0d expected 16/16/0", n, free_cnt, enq_ptr); end
    test_random(300);
  endtask

  // Test sequence
  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_fifo();
    test_full();
    test_same_queue();
    test_last_free_rel();
    test_random(600);
    drain_all();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
